traffic_phase_ctrl: RTL and testbench
=====================================

// Module: traffic_phase_ctrl
// PURPOSE
//  Downstream consumer of the 6-bit traffic cycle counter (0..53, wraps to 0).
//  - Decodes the count into light phases for two roads, NS and EW.
//  - Drives registered light outputs and serves a latched pedestrian request.
//  - Checks count continuity; on a bad count it enters a flashing-red fault mode.
//  - Counter updates on negedge clk; this block samples cnt on posedge clk.
// PARAMETERS
//  N          6   count width
//  CNT_MAX    53  last count before wrap
//  NS_Y_START 21  first NS yellow count (NS green is 0..20)
//  AR1_START  25  first all-red count after NS yellow (NS yellow is 21..24)
//  EW_G_START 27  first EW green count (all-red is 25..26)
//  EW_Y_START 48  first EW yellow count
//  AR2_START  52  first all-red count after EW yellow (all-red is 52..53)
//  WALK_LEN   12  walk duration in counts, starting at EW_G_START
//  FLASH_DIV  4   fault red toggles every FLASH_DIV clocks
// PORTS
//  clk       in   1  clock
//  rst_n     in   1  asynchronous active-low reset
//  cnt       in   N  cycle count from the counter
//  ped_req   in   1  pedestrian request, level or pulse, sampled on posedge
//  ns_light  out  3  {red,yellow,green}, one-hot; 3'b000 only during fault flash-off
//  ew_light  out  3  {red,yellow,green}, one-hot; same rule as ns_light
//  walk      out  1  walk signal for crossing the NS road
//  ped_ack   out  1  one-clock pulse when walk starts
//  fault     out  1  count continuity fault is active
// BEHAVIOUR
//  Reset values:
//  - state=SYNC; ns_light=ew_light=3'b100; walk=0; ped_ack=0; fault=0.
//  - ped_pending=0; flash counter=0.
//  SYNC: all red; holds until cnt==0 is sampled, then goes to NS_G.
//  Phase sequence: NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G.
//  - Each transition fires on the edge where the sampled cnt equals the next
//    phase's start value. AR2 -> NS_G fires on cnt==0.
//  Lights are registered and change on the same edge as the state.
//  - Latency is one posedge after the count change.
//  - In NS_G/NS_Y, EW is red; in EW_G/EW_Y, NS is red; in AR1/AR2 both are red.
//  Continuity check, active in every state except SYNC and FAULT:
//  - Compares sampled cnt with prev_cnt.
//  - Legal if cnt==prev_cnt (sampled twice between negedges), cnt==prev_cnt+1,
//    or prev_cnt==CNT_MAX and cnt==0.
//  - cnt>CNT_MAX is always illegal.
//  - An illegal sample moves the state to FAULT on that edge.
//  FAULT:
//  - fault=1; walk=0; ped_pending cleared.
//  - Both reds toggle together every FLASH_DIV clocks, starting ON.
//  - Sampling cnt==0 exits to NS_G with fault=0 on that edge.
//  Pedestrian:
//  - ped_req sets ped_pending unless the state is FAULT.
//  - On the EW_G entry edge with ped_pending=1: walk=1, ped_ack=1 for one clock,
//    ped_pending cleared.
//  - A ped_req on that same edge is absorbed and is not re-latched.
//  - walk drops on the edge where cnt==EW_G_START+WALK_LEN, or on any exit from EW_G.
//  - A ped_req during walk latches for the next cycle.
//  rst_n low mid-operation: everything returns to reset values immediately.
//  No arithmetic overflow: prev_cnt+1 is computed at N+1 bits.
// STRUCTURE
//  traffic_pkg holds:
//  - phase boundary localparams and state encoding (SYNC, NS_G, NS_Y, AR1, EW_G,
//    EW_Y, AR2, FAULT);
//  - light codes RED=3'b100, YEL=3'b010, GRN=3'b001.
//  Sub-module traffic_flash_gen: FLASH_DIV divider giving flash_on; enabled only in FAULT.
// TESTING
//  1) Release reset with cnt free-running from 5 -> stays all red until cnt==0;
//     NS green at cnt 0, NS yellow at 21, both red at 25, EW green at 27,
//     EW yellow at 48, both red at 52.
//  2) ped_req pulse at cnt=10 -> at cnt=27: walk=1 and a single ped_ack;
//     walk=0 when cnt reaches 39.
//  3) ped_req held high through cnt=27 -> exactly one ped_ack; next ped_req at
//     cnt=30 -> walk again in the following cycle at cnt=27.
//  4) Force cnt 14->20 -> fault=1 on that edge; reds flash 4 on / 4 off;
//     ped_req ignored; cnt=0 -> NS green, fault=0.
//  5) Force cnt=60 -> fault. Wrap 53->0 and repeated identical samples -> no fault.
//  6) Assert rst_n low during EW_G with walk=1 -> walk=0, all red, state SYNC
//     immediately.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic phase controller.
//   - Phase boundary counts of the 0..53 traffic cycle.
//   - Controller state encoding.
//   - Light codes, packed as {red,yellow,green}.
//   - Helper functions for light decode and count-continuity checking.
package traffic_pkg;

  localparam int N = 6;

  localparam logic [N-1:0] CNT_ZERO   = 6'd0;
  localparam logic [N-1:0] CNT_MAX    = 6'd53;
  localparam logic [N-1:0] NS_Y_START = 6'd21;
  localparam logic [N-1:0] AR1_START  = 6'd25;
  localparam logic [N-1:0] EW_G_START = 6'd27;
  localparam logic [N-1:0] EW_Y_START = 6'd48;
  localparam logic [N-1:0] AR2_START  = 6'd52;
  localparam logic [N-1:0] WALK_LEN   = 6'd12;
  // First count on which walk is no longer shown.
  localparam logic [N-1:0] WALK_END   = EW_G_START + WALK_LEN;

  localparam int FLASH_DIV = 4;
  localparam int FLASH_W   = $clog2(FLASH_DIV);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR1   = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    AR2   = 3'd6,
    FAULT = 3'd7
  } state_t;

  // Steady light pattern {ns,ew} for a state; SYNC and FAULT fall back to all red.
  function automatic logic [5:0] phase_lights(input state_t s);
    logic [5:0] l;
    case (s)
      NS_G:    l = {GRN, RED};
      NS_Y:    l = {YEL, RED};
      AR1:     l = {RED, RED};
      EW_G:    l = {RED, GRN};
      EW_Y:    l = {RED, YEL};
      AR2:     l = {RED, RED};
      default: l = {RED, RED};
    endcase
    return l;
  endfunction

  // A count is legal if it repeats, advances by one, or wraps from CNT_MAX to 0.
  // The increment is done one bit wider so 63+1 can never alias to 0.
  function automatic logic cnt_legal(input logic [N-1:0] prev, input logic [N-1:0] cur);
    logic [N:0] prev_inc;
    logic       ok;
    prev_inc = {1'b0, prev} + {{N{1'b0}}, 1'b1};
    if (cur > CNT_MAX) begin
      ok = 1'b0;
    end else if (cur == prev) begin
      ok = 1'b1;
    end else if ({1'b0, cur} == prev_inc) begin
      ok = 1'b1;
    end else if ((prev == CNT_MAX) && (cur == CNT_ZERO)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/traffic_flash_gen.sv
// traffic_flash_gen: divider for the fault-mode red flash.
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   en       in  high while the controller sits in FAULT
//   flash_on out phase the reds must take on the current edge (1 = lit)
// While disabled the divider rests at zero with the phase ON, so the first
// FLASH_DIV clocks of a fault are lit, the next FLASH_DIV dark, and so on.
module traffic_flash_gen
  import traffic_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic flash_on
);

  logic [FLASH_W-1:0] div_r;
  logic               phase_r;
  logic               tick_s;

  assign tick_s   = en && (div_r == FLASH_W'(FLASH_DIV - 1));
  // Look-ahead phase so the registered lights flip exactly on the tick edge.
  assign flash_on = tick_s ? ~phase_r : phase_r;

  // Divider and flash phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r   <= {FLASH_W{1'b0}};
      phase_r <= 1'b1;
    end else if (!en) begin
      div_r   <= {FLASH_W{1'b0}};
      phase_r <= 1'b1;
    end else if (tick_s) begin
      div_r   <= {FLASH_W{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      div_r   <= div_r + FLASH_W'(1);
      phase_r <= phase_r;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: decodes the traffic cycle count into NS/EW light phases,
// serves a latched pedestrian request and drops into a flashing-red fault mode
// when the count stream breaks continuity.
//   clk      in  clock (count changes on negedge, sampled here on posedge)
//   rst_n    in  asynchronous active-low reset
//   cnt      in  cycle count 0..53
//   ped_req  in  pedestrian request, level or pulse
//   ns_light out {red,yellow,green} for NS, 000 only while fault flash is dark
//   ew_light out {red,yellow,green} for EW, same rule
//   walk     out walk signal for crossing the NS road
//   ped_ack  out one-clock pulse on the edge walk starts
//   fault    out continuity fault active
module traffic_phase_ctrl
  import traffic_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] cnt,
  input  logic         ped_req,
  output logic [2:0]   ns_light,
  output logic [2:0]   ew_light,
  output logic         walk,
  output logic         ped_ack,
  output logic         fault
);

  state_t       state_r;
  state_t       state_nx_s;
  logic [N-1:0] prev_cnt_r;
  logic         ped_pending_r;
  logic         legal_s;
  logic         flash_en_s;
  logic         flash_on_s;
  logic         walk_start_s;

  assign legal_s    = cnt_legal(prev_cnt_r, cnt);
  assign flash_en_s = (state_r == FAULT);

  traffic_flash_gen u_flash (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (flash_en_s),
    .flash_on (flash_on_s)
  );

  // Next phase: each run phase advances when the sampled count hits the next
  // phase's start; any continuity break overrides the advance.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      SYNC:    state_nx_s = (cnt == CNT_ZERO) ? NS_G : SYNC;
      FAULT:   state_nx_s = (cnt == CNT_ZERO) ? NS_G : FAULT;
      NS_G:    state_nx_s = !legal_s ? FAULT : ((cnt == NS_Y_START) ? NS_Y : NS_G);
      NS_Y:    state_nx_s = !legal_s ? FAULT : ((cnt == AR1_START)  ? AR1  : NS_Y);
      AR1:     state_nx_s = !legal_s ? FAULT : ((cnt == EW_G_START) ? EW_G : AR1);
      EW_G:    state_nx_s = !legal_s ? FAULT : ((cnt == EW_Y_START) ? EW_Y : EW_G);
      EW_Y:    state_nx_s = !legal_s ? FAULT : ((cnt == AR2_START)  ? AR2  : EW_Y);
      AR2:     state_nx_s = !legal_s ? FAULT : ((cnt == CNT_ZERO)   ? NS_G : AR2);
      default: state_nx_s = FAULT;
    endcase
  end

  // Walk begins only on the edge that enters EW_G with a request waiting.
  assign walk_start_s = (state_nx_s == EW_G) && (state_r != EW_G) && ped_pending_r;

  // Controller state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= SYNC;
      prev_cnt_r    <= CNT_ZERO;
      ped_pending_r <= 1'b0;
      ns_light      <= RED;
      ew_light      <= RED;
      walk          <= 1'b0;
      ped_ack       <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      prev_cnt_r <= cnt;
      ped_ack    <= walk_start_s;
      fault      <= (state_nx_s == FAULT);
      if (state_nx_s == FAULT) begin
        ns_light      <= flash_on_s ? RED : OFF;
        ew_light      <= flash_on_s ? RED : OFF;
        walk          <= 1'b0;
        ped_pending_r <= 1'b0;
      end else begin
        {ns_light, ew_light} <= phase_lights(state_nx_s);
        if (walk_start_s) begin
          // A request arriving on the start edge is served by this walk.
          walk          <= 1'b1;
          ped_pending_r <= 1'b0;
        end else begin
          if ((state_nx_s != EW_G) || (cnt == WALK_END)) begin
            walk <= 1'b0;
          end else begin
            walk <= walk;
          end
          // Requests seen on the fault-exit edge still belong to the fault.
          ped_pending_r <= ped_pending_r | (ped_req & (state_r != FAULT));
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed testbench for traffic_phase_ctrl. The count is driven on negedge
// like the real counter; outputs are sampled 1 time unit after posedge.
module tb_traffic_phase_ctrl;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;
  localparam int         NOREQ = -1;

  logic       clk;
  logic       rst_n;
  logic [5:0] cnt;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic       fault;

  int n_checks;
  int n_errors;

  traffic_phase_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .ped_ack  (ped_ack),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One counter step: new count on negedge, DUT samples on posedge.
  task automatic tick(input int c, input logic r);
    @(negedge clk);
    cnt     = c[5:0];
    ped_req = r;
    @(posedge clk);
    #1;
  endtask

  // Step counts lo..hi, requesting while the count lies in req_lo..req_hi.
  task automatic run(input int lo, input int hi, input int req_lo, input int req_hi);
    for (int c = lo; c <= hi; c++) begin
      tick(c, (c >= req_lo) && (c <= req_hi));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    cnt      = 6'd5;
    ped_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ns",    ns_light, L_RED);
    check_eq("rst_ew",    ew_light, L_RED);
    check_eq("rst_walk",  walk,     1'b0);
    check_eq("rst_ack",   ped_ack,  1'b0);
    check_eq("rst_fault", fault,    1'b0);

    // 1) sync on count 0, then full phase sequence
    @(negedge clk);
    rst_n = 1'b1;
    run(5, 53, NOREQ, NOREQ);
    check_eq("sync_ns", ns_light, L_RED);
    check_eq("sync_ew", ew_light, L_RED);
    tick(0, 1'b0);
    check_eq("c0_ns", ns_light, L_GRN);
    check_eq("c0_ew", ew_light, L_RED);
    run(1, 20, NOREQ, NOREQ);
    check_eq("c20_ns", ns_light, L_GRN);
    tick(21, 1'b0);
    check_eq("c21_ns", ns_light, L_YEL);
    check_eq("c21_ew", ew_light, L_RED);
    run(22, 24, NOREQ, NOREQ);
    tick(25, 1'b0);
    check_eq("c25_ns", ns_light, L_RED);
    check_eq("c25_ew", ew_light, L_RED);
    tick(26, 1'b0);
    tick(27, 1'b0);
    check_eq("c27_ns",   ns_light, L_RED);
    check_eq("c27_ew",   ew_light, L_GRN);
    check_eq("c27_walk", walk,     1'b0);
    run(28, 47, NOREQ, NOREQ);
    tick(48, 1'b0);
    check_eq("c48_ns", ns_light, L_RED);
    check_eq("c48_ew", ew_light, L_YEL);
    run(49, 51, NOREQ, NOREQ);
    tick(52, 1'b0);
    check_eq("c52_ns", ns_light, L_RED);
    check_eq("c52_ew", ew_light, L_RED);
    tick(53, 1'b0);

    // 2) pulse request at 10, walk 27..38
    run(0, 9, NOREQ, NOREQ);
    tick(10, 1'b1);
    run(11, 26, NOREQ, NOREQ);
    tick(27, 1'b0);
    check_eq("p2_walk27", walk,    1'b1);
    check_eq("p2_ack27",  ped_ack, 1'b1);
    tick(28, 1'b0);
    check_eq("p2_ack28",  ped_ack, 1'b0);
    check_eq("p2_walk28", walk,    1'b1);
    run(29, 38, NOREQ, NOREQ);
    check_eq("p2_walk38", walk, 1'b1);
    tick(39, 1'b0);
    check_eq("p2_walk39", walk, 1'b0);
    run(40, 53, NOREQ, NOREQ);

    // 3) request held through 27 is absorbed; request at 30 latches
    run(0, 19, NOREQ, NOREQ);
    run(20, 26, 20, 26);
    tick(27, 1'b1);
    check_eq("p3_walk27", walk,    1'b1);
    check_eq("p3_ack27",  ped_ack, 1'b1);
    tick(28, 1'b0);
    check_eq("p3_ack28",  ped_ack, 1'b0);
    tick(29, 1'b0);
    tick(30, 1'b1);
    run(31, 53, NOREQ, NOREQ);
    run(0, 26, NOREQ, NOREQ);
    tick(27, 1'b0);
    check_eq("p3_next_walk", walk,    1'b1);
    check_eq("p3_next_ack",  ped_ack, 1'b1);
    run(28, 53, NOREQ, NOREQ);
    run(0, 26, NOREQ, NOREQ);
    tick(27, 1'b0);
    check_eq("p3_none_walk", walk,    1'b0);
    check_eq("p3_none_ack",  ped_ack, 1'b0);
    run(28, 53, NOREQ, NOREQ);

    // 4) jump 14->20 faults; reds flash 4 on / 4 off; requests ignored
    run(0, 14, NOREQ, NOREQ);
    tick(20, 1'b0);
    check_eq("f4_fault", fault,    1'b1);
    check_eq("f4_ns",    ns_light, L_RED);
    check_eq("f4_ew",    ew_light, L_RED);
    tick(21, 1'b1);
    tick(22, 1'b1);
    tick(23, 1'b1);
    check_eq("f4_on3_ns", ns_light, L_RED);
    check_eq("f4_on3_ew", ew_light, L_RED);
    tick(24, 1'b1);
    check_eq("f4_off4_ns", ns_light, L_OFF);
    check_eq("f4_off4_ew", ew_light, L_OFF);
    tick(25, 1'b1);
    tick(26, 1'b1);
    tick(27, 1'b1);
    check_eq("f4_off7_ns", ns_light, L_OFF);
    check_eq("f4_fault7",  fault,    1'b1);
    check_eq("f4_walk7",   walk,     1'b0);
    tick(28, 1'b1);
    check_eq("f4_on8_ns", ns_light, L_RED);
    check_eq("f4_on8_ew", ew_light, L_RED);
    tick(0, 1'b0);
    check_eq("f4_exit_fault", fault,    1'b0);
    check_eq("f4_exit_ns",    ns_light, L_GRN);
    check_eq("f4_exit_ew",    ew_light, L_RED);
    run(1, 26, NOREQ, NOREQ);
    tick(27, 1'b0);
    check_eq("f4_ped_ignored", walk, 1'b0);
    run(28, 53, NOREQ, NOREQ);

    // 5) out-of-range count faults; wrap and repeats are legal
    tick(60, 1'b0);
    check_eq("f5_c60_fault", fault, 1'b1);
    tick(0, 1'b0);
    check_eq("f5_exit_fault", fault,    1'b0);
    check_eq("f5_exit_ns",    ns_light, L_GRN);
    tick(1, 1'b0);
    tick(1, 1'b0);
    check_eq("f5_repeat_fault", fault, 1'b0);
    run(2, 53, NOREQ, NOREQ);
    tick(0, 1'b0);
    check_eq("f5_wrap_fault", fault,    1'b0);
    check_eq("f5_wrap_ns",    ns_light, L_GRN);
    tick(0, 1'b0);
    check_eq("f5_rep0_fault", fault, 1'b0);
    run(1, 53, NOREQ, NOREQ);
    tick(54, 1'b0);
    check_eq("f5_c54_fault", fault, 1'b1);
    tick(0, 1'b0);
    check_eq("f5_c54_exit", fault, 1'b0);

    // 6) async reset during a walk
    run(1, 4, NOREQ, NOREQ);
    tick(5, 1'b1);
    run(6, 26, NOREQ, NOREQ);
    tick(27, 1'b0);
    check_eq("r6_walk_pre", walk, 1'b1);
    run(28, 30, NOREQ, NOREQ);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("r6_walk",  walk,     1'b0);
    check_eq("r6_ns",    ns_light, L_RED);
    check_eq("r6_ew",    ew_light, L_RED);
    check_eq("r6_fault", fault,    1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(31, 40, NOREQ, NOREQ);
    tick(50, 1'b0);
    check_eq("r6_sync_fault", fault,    1'b0);
    check_eq("r6_sync_ns",    ns_light, L_RED);
    check_eq("r6_sync_ew",    ew_light, L_RED);
    tick(0, 1'b0);
    check_eq("r6_resync_ns", ns_light, L_GRN);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
